// File: rtl/sim_termination_collector.sv
// Collects per-core termination and retire strobes into a done/hang verdict.
// A drain window follows global completion, and a retire watchdog flags hangs.
module sim_termination_collector #(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter int unsigned CNT_WIDTH      = 32,
  localparam int unsigned IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CORES-1:0] termination,
  input  logic [NUM_CORES-1:0] trace_valid,
  input  logic                 clear,
  output logic [NUM_CORES-1:0] term_mask,
  output logic                 all_terminated,
  output logic                 done,
  output logic                 hang,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [IDW-1:0]       first_core,
  output logic [IDW-1:0]       last_core
);

  localparam int unsigned TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam int unsigned DW_RAW = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned DW     = (DW_RAW < 1) ? 1 : DW_RAW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_HANG  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic                 all_term_q, all_term_d;
  logic                 done_q, done_d;
  logic                 hang_q, hang_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [TW-1:0]        idle_q, idle_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic [IDW-1:0]       first_q, first_d;
  logic [IDW-1:0]       last_q, last_d;

  logic [NUM_CORES-1:0] mask_new, rise;
  logic [IDW-1:0]       lo_idx, hi_idx;
  logic                 run_cycle;

  assign mask_new = mask_q | termination;
  assign rise     = termination & ~mask_q;

  // Lowest and highest newly set core index in this cycle
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (rise[i]) lo_idx = IDW'(i);
    end
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (rise[i]) hi_idx = IDW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    all_term_d = all_term_q;
    done_d     = done_q;
    hang_d     = hang_q;
    cyc_d      = cyc_q;
    idle_d     = idle_q;
    drain_d    = drain_q;
    first_d    = first_q;
    last_d     = last_q;
    run_cycle  = 1'b0;

    unique case (state_q)
      S_IDLE:  run_cycle = (|trace_valid) | (|termination);
      S_RUN:   run_cycle = 1'b1;
      S_DRAIN: begin
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + CNT_WIDTH'(1);
        if (drain_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      S_DONE:  ;
      S_HANG:  ;
      default: state_d = S_IDLE;
    endcase

    // The IDLE exit cycle is handled exactly like a RUN cycle
    if (run_cycle) begin
      state_d = S_RUN;
      mask_d  = mask_new;
      cyc_d   = (&cyc_q) ? cyc_q : cyc_q + CNT_WIDTH'(1);
      idle_d  = (|trace_valid) ? '0 : idle_q + TW'(1);
      if ((mask_q == '0) && (rise != '0)) first_d = lo_idx;
      if (&mask_new) begin
        state_d    = S_DRAIN;
        drain_d    = DW'(DRAIN_CYCLES);
        all_term_d = 1'b1;
        last_d     = hi_idx;
      end else if (!(|trace_valid) && (idle_q == TW'(TIMEOUT_CYCLES - 1))) begin
        state_d = S_HANG;
        hang_d  = 1'b1;
      end
    end

    if (clear) begin
      state_d    = S_IDLE;
      mask_d     = '0;
      all_term_d = 1'b0;
      done_d     = 1'b0;
      hang_d     = 1'b0;
      cyc_d      = '0;
      idle_d     = '0;
      drain_d    = '0;
      first_d    = '0;
      last_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      all_term_q <= 1'b0;
      done_q     <= 1'b0;
      hang_q     <= 1'b0;
      cyc_q      <= '0;
      idle_q     <= '0;
      drain_q    <= '0;
      first_q    <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      all_term_q <= all_term_d;
      done_q     <= done_d;
      hang_q     <= hang_d;
      cyc_q      <= cyc_d;
      idle_q     <= idle_d;
      drain_q    <= drain_d;
      first_q    <= first_d;
      last_q     <= last_d;
    end
  end

  assign term_mask      = mask_q;
  assign all_terminated = all_term_q;
  assign done           = done_q;
  assign hang           = hang_q;
  assign cycle_count    = cyc_q;
  assign first_core     = first_q;
  assign last_core      = last_q;

endmodule

// File: tb/tb_sim_termination_collector.sv
// Directed bench for sim_termination_collector: completion, hang, race,
// reset/clear, counter saturation and the single-core configuration.
module tb_sim_termination_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] termination;
  logic [3:0] trace_valid;
  logic       clear;

  logic [3:0]  a_mask;
  logic        a_all, a_done, a_hang;
  logic [31:0] a_cnt;
  logic [1:0]  a_first, a_last;

  logic [3:0] b_mask;
  logic       b_all, b_done, b_hang;
  logic [3:0] b_cnt;
  logic [1:0] b_first, b_last;

  logic [0:0]  c_mask;
  logic        c_all, c_done, c_hang;
  logic [31:0] c_cnt;
  logic [0:0]  c_first, c_last;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sim_termination_collector #(.NUM_CORES(4), .TIMEOUT_CYCLES(100), .DRAIN_CYCLES(16),
                              .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .termination(termination), .trace_valid(trace_valid),
    .clear(clear), .term_mask(a_mask), .all_terminated(a_all), .done(a_done),
    .hang(a_hang), .cycle_count(a_cnt), .first_core(a_first), .last_core(a_last));

  sim_termination_collector #(.NUM_CORES(4), .TIMEOUT_CYCLES(100), .DRAIN_CYCLES(0),
                              .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .termination(termination), .trace_valid(trace_valid),
    .clear(clear), .term_mask(b_mask), .all_terminated(b_all), .done(b_done),
    .hang(b_hang), .cycle_count(b_cnt), .first_core(b_first), .last_core(b_last));

  sim_termination_collector #(.NUM_CORES(1), .TIMEOUT_CYCLES(100), .DRAIN_CYCLES(2),
                              .CNT_WIDTH(32)) dut_c (
    .clk(clk), .rst(rst), .termination(termination[0:0]), .trace_valid(trace_valid[0:0]),
    .clear(clear), .term_mask(c_mask), .all_terminated(c_all), .done(c_done),
    .hang(c_hang), .cycle_count(c_cnt), .first_core(c_first), .last_core(c_last));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    termination = '0; trace_valid = '0; clear = 1'b0; rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  // Cycle 0 idle, retires from cycle 1, cores 2,0,3,1 terminate at 10,20,30,40
  task automatic run_scenario1(input string tag);
    termination = '0; trace_valid = '0;
    tick();
    for (int c = 1; c <= 60; c++) begin
      trace_valid = 4'hF;
      if (c == 10) termination[2] = 1'b1;
      if (c == 20) termination[0] = 1'b1;
      if (c == 30) termination[3] = 1'b1;
      if (c == 40) termination[1] = 1'b1;
      tick();
      if (c == 39 || c == 40) begin
        tests_run++;
        if (a_all !== (c == 40)) begin tests_failed++;
          $display("FAIL %s all_terminated@%0d: got %b expected %b", tag, c + 1, a_all, c == 40); end
      end
      if (c == 56 || c == 57) begin
        tests_run++;
        if (a_done !== (c == 57)) begin tests_failed++;
          $display("FAIL %s done@%0d: got %b expected %b", tag, c + 1, a_done, c == 57); end
      end
    end
    tests_run++;
    if (a_cnt !== 32'd57) begin tests_failed++;
      $display("FAIL %s cycle_count: got %0d expected 57", tag, a_cnt); end
    tests_run++;
    if (a_first !== 2'd2 || a_last !== 2'd1) begin tests_failed++;
      $display("FAIL %s first/last: got %0d/%0d expected 2/1", tag, a_first, a_last); end
    tests_run++;
    if (a_hang !== 1'b0 || a_mask !== 4'hF) begin tests_failed++;
      $display("FAIL %s hang/mask: got %b/%h expected 0/f", tag, a_hang, a_mask); end
    termination = '0; trace_valid = '0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({a_mask, a_all, a_done, a_hang, a_cnt, a_first, a_last} !== '0) begin tests_failed++;
      $display("FAIL reset_outputs: got mask=%h all=%b done=%b hang=%b cnt=%0d first=%0d last=%0d expected all 0",
               a_mask, a_all, a_done, a_hang, a_cnt, a_first, a_last); end
    ticks(5);
    tests_run++;
    if (a_cnt !== 32'd0 || a_hang !== 1'b0) begin tests_failed++;
      $display("FAIL idle_hold: got cnt=%0d hang=%b expected 0/0", a_cnt, a_hang); end
  endtask

  task automatic test_normal();
    do_reset();
    run_scenario1("normal");
  endtask

  task automatic test_simultaneous();
    do_reset();
    trace_valid = 4'hF;
    tick();
    termination = 4'b1010;
    ticks(2);
    termination = 4'b1111;
    tick();
    tests_run++;
    if (a_all !== 1'b1 || a_first !== 2'd1 || a_last !== 2'd2) begin tests_failed++;
      $display("FAIL simultaneous: got all=%b first=%0d last=%0d expected 1/1/2", a_all, a_first, a_last); end
  endtask

  task automatic test_hang();
    do_reset();
    trace_valid = 4'hF;
    termination = 4'b0001;
    tick();
    termination = 4'b0000;
    ticks(9);
    trace_valid = '0;
    ticks(99);
    tests_run++;
    if (a_hang !== 1'b0) begin tests_failed++;
      $display("FAIL hang_early: got %b expected 0", a_hang); end
    tick();
    tests_run++;
    if (a_hang !== 1'b1 || a_done !== 1'b0) begin tests_failed++;
      $display("FAIL hang_rise: got hang=%b done=%b expected 1/0", a_hang, a_done); end
    termination = 4'b1110;
    ticks(3);
    tests_run++;
    if (a_hang !== 1'b1 || a_mask !== 4'b0001 || a_all !== 1'b0) begin tests_failed++;
      $display("FAIL hang_sticky: got hang=%b mask=%h all=%b expected 1/1/0", a_hang, a_mask, a_all); end
    termination = '0;
  endtask

  task automatic test_race();
    do_reset();
    trace_valid = 4'hF;
    termination = 4'b0111;
    tick();
    trace_valid = '0;
    ticks(99);
    termination = 4'b1111;
    tick();
    tests_run++;
    if (a_all !== 1'b1 || a_hang !== 1'b0 || a_last !== 2'd3) begin tests_failed++;
      $display("FAIL race_drain: got all=%b hang=%b last=%0d expected 1/0/3", a_all, a_hang, a_last); end
    ticks(16);
    tests_run++;
    if (a_done !== 1'b0) begin tests_failed++;
      $display("FAIL race_done_early: got %b expected 0", a_done); end
    tick();
    tests_run++;
    if (a_done !== 1'b1 || a_hang !== 1'b0) begin tests_failed++;
      $display("FAIL race_done: got done=%b hang=%b expected 1/0", a_done, a_hang); end
    termination = '0;
  endtask

  task automatic test_reset_clear();
    do_reset();
    trace_valid = 4'hF; termination = 4'hF;
    tick();
    ticks(5);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({a_mask, a_all, a_done, a_hang, a_cnt, a_first, a_last} !== '0) begin tests_failed++;
      $display("FAIL async_rst: got mask=%h all=%b cnt=%0d last=%0d expected 0", a_mask, a_all, a_cnt, a_last); end
    trace_valid = '0; termination = '0;
    #1 rst = 1'b0;
    ticks(3);
    tests_run++;
    if (a_cnt !== 32'd0 || a_all !== 1'b0) begin tests_failed++;
      $display("FAIL rst_idle: got cnt=%0d all=%b expected 0/0", a_cnt, a_all); end
    trace_valid = 4'hF; termination = 4'hF;
    ticks(4);
    clear = 1'b1;
    tick();
    clear = 1'b0; trace_valid = '0; termination = '0;
    tests_run++;
    if ({a_mask, a_all, a_done, a_hang, a_cnt, a_first, a_last} !== '0) begin tests_failed++;
      $display("FAIL clear: got mask=%h all=%b cnt=%0d last=%0d expected 0", a_mask, a_all, a_cnt, a_last); end
    ticks(3);
    tests_run++;
    if (a_cnt !== 32'd0) begin tests_failed++;
      $display("FAIL clear_idle: got cnt=%0d expected 0", a_cnt); end
    run_scenario1("rerun");
  endtask

  task automatic test_saturation();
    do_reset();
    trace_valid = 4'hF;
    ticks(14);
    tests_run++;
    if (b_cnt !== 4'd14) begin tests_failed++;
      $display("FAIL sat_count14: got %0d expected 14", b_cnt); end
    ticks(6);
    tests_run++;
    if (b_cnt !== 4'd15) begin tests_failed++;
      $display("FAIL sat_hold: got %0d expected 15", b_cnt); end
    termination = 4'hF;
    tick();
    tests_run++;
    if (b_all !== 1'b1 || b_done !== 1'b0) begin tests_failed++;
      $display("FAIL sat_drain: got all=%b done=%b expected 1/0", b_all, b_done); end
    tick();
    tests_run++;
    if (b_done !== 1'b1 || b_cnt !== 4'd15) begin tests_failed++;
      $display("FAIL sat_done: got done=%b cnt=%0d expected 1/15", b_done, b_cnt); end
    termination = '0; trace_valid = '0;
  endtask

  task automatic test_single_core();
    do_reset();
    termination = 4'b0001;
    tick();
    tests_run++;
    if (c_all !== 1'b1 || c_mask !== 1'b1 || c_first !== 1'b0 || c_last !== 1'b0) begin tests_failed++;
      $display("FAIL single_core: got all=%b mask=%b first=%0d last=%0d expected 1/1/0/0",
               c_all, c_mask, c_first, c_last); end
    ticks(2);
    tests_run++;
    if (c_done !== 1'b0) begin tests_failed++;
      $display("FAIL single_done_early: got %b expected 0", c_done); end
    tick();
    tests_run++;
    if (c_done !== 1'b1 || c_hang !== 1'b0 || c_cnt !== 32'd4) begin tests_failed++;
      $display("FAIL single_done: got done=%b hang=%b cnt=%0d expected 1/0/4", c_done, c_hang, c_cnt); end
    termination = '0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; termination = '0; trace_valid = '0;
    test_reset();
    test_normal();
    test_simultaneous();
    test_hang();
    test_race();
    test_reset_clear();
    test_saturation();
    test_single_core();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
